io_write_arbiter: RTL and testbench
===================================

# io_write_arbiter

Arbitrates write traffic from two requesters onto the single write port of the output-port block: the CPU store path (requester 0) and the debug/monitor write path (requester 1). Each requester has a one-entry holding buffer. A round-robin scheduler issues at most one registered write per cycle as io_addr/io_data/io_we. Writes to addresses outside the output-port window are dropped and flagged.

## Interface
Parameters:
- PORT_BASE, 6'b100000, addr[7:2] value of the first output port (80h)
- PORT_COUNT, 3, number of consecutive valid port slots (80h, 84h, 88h)

Ports:
- io_clk  in  1  single clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- req0  in  1  requester 0 write request
- addr0  in  32  requester 0 write address
- data0  in  32  requester 0 write data
- rdy0  out  1  requester 0 buffer empty; request accepted when req0 && rdy0 at a rising edge
- req1 / addr1 / data1 / rdy1  same as requester 0, for requester 1
- io_addr  out  32  registered write address to the output-port block
- io_data  out  32  registered write data
- io_we  out  1  registered write enable, one cycle per issued write
- busy  out  1  pend0 | pend1
- err  out  1  sticky: a dropped out-of-window write occurred
- err_src  out  1  requester of the most recent dropped write
- err_clr  in  1  synchronous clear of err

## Operation
- State: pend0/pend1 with buffers baddr0/bdata0 and baddr1/bdata1; last_grant (1 bit); output registers; err and err_src.
- Accept: at an edge with reqN && rdyN, capture addrN/dataN into bufferN and set pendN. rdyN = ~pendN (combinational). A request while rdyN=0 is ignored, and the requester holds it.
- Select, combinational from pend:
  - none pending: no grant
  - one pending: grant it
  - both pending: grant the requester != last_grant
- Grant, at the edge:
  - clear pendG and set last_grant <= G
  - If baddrG[7:2] is in [PORT_BASE, PORT_BASE+PORT_COUNT-1]: io_we<=1, io_addr<=baddrG, io_data<=bdataG.
  - Else: io_we<=0, err<=1, err_src<=G; io_addr/io_data hold their values.
  - A dropped write still consumes the turn.
- No grant: io_we<=0; io_addr/io_data hold their values.
- err_clr: err<=0 on the next edge. A simultaneous drop wins: err=1 and err_src updates.
- A requester cannot be accepted and granted in the same cycle, because a grant requires pend=1 and acceptance requires pend=0.
- Only addr[7:2] is decoded; upper bits pass through unchanged on io_addr.

## Timing
- Reset (resetn=0, asynchronous): pend0=pend1=0; last_grant=1, so requester 0 wins the first tie; io_we=0; io_addr=0; io_data=0; err=0; err_src=0; busy=0; rdy0=rdy1=1.
- Latency:
  - request accepted at edge N
  - io_we high during cycle N+1 to N+2, after edge N+1
  - output-port block captures at edge N+2
- rdyN returns high after edge N+1.
- Throughput:
  - one write per 2 cycles per requester
  - with both requesters streaming, one write per cycle, alternating 0,1,0,1
- Both requests are accepted at the same edge. Both are issued on consecutive cycles, ordered by last_grant.
- resetn asserted mid-operation: pending writes are discarded and io_we drops immediately; no partial write is issued.
- Writes are issued in order within each requester; there is no ordering guarantee across requesters.

## Test plan
- Reset: hold resetn=0 for 3 cycles with req0=1 -> io_we=0, io_addr=0, io_data=0, rdy0=rdy1=1, err=0; no acceptance during reset.
- Single write: req0 with addr0=32'h80, data0=32'h1234 accepted at edge N -> io_we=1, io_addr=32'h80, io_data=32'h1234 for exactly one cycle after edge N+1; rdy0 high again after edge N+1.
- Tie after reset: req0 (addr 84h, data A5A5) and req1 (addr 88h, data 5A5A) accepted at the same edge -> requester 0 written first, requester 1 on the next cycle; last_grant ends at 1.
- Streaming fairness:
  - both requesters hold req high for 20 cycles with valid addresses
  - required: io_we sequence alternates 0,1,0,1 with no starvation
  - required: write counts per requester differ by at most 1
- Drop and error:
  - req1 with addr1=32'h8C is accepted
  - required: no io_we pulse; err=1 and err_src=1 on the grant edge
  - apply err_clr together with a new drop from requester 0: err stays 1 and err_src=0
  - apply err_clr alone: err=0
- Reset mid-flight: assert resetn low while pend0=1 and pend1=1 -> io_we=0 immediately; after release, no stale write appears on io_we.

Source files
------------

// File: rtl/io_write_arbiter.sv
// rtl/io_write_arbiter.sv - round-robin arbiter of two one-entry write buffers onto the output-port write bus
// Out-of-window writes are dropped with a sticky error flag.
module io_write_arbiter #(
  parameter logic [5:0]  PORT_BASE  = 6'b100000,
  parameter int unsigned PORT_COUNT = 3
) (
  input  logic        io_clk,
  input  logic        resetn,
  input  logic        req0,
  input  logic [31:0] addr0,
  input  logic [31:0] data0,
  output logic        rdy0,
  input  logic        req1,
  input  logic [31:0] addr1,
  input  logic [31:0] data1,
  output logic        rdy1,
  output logic [31:0] io_addr,
  output logic [31:0] io_data,
  output logic        io_we,
  output logic        busy,
  output logic        err,
  output logic        err_src,
  input  logic        err_clr
);

  // One extra bit so PORT_BASE + PORT_COUNT cannot wrap the slot compare.
  localparam logic [6:0] WIN_LO = {1'b0, PORT_BASE};
  localparam logic [6:0] WIN_HI = WIN_LO + 7'(PORT_COUNT) - 7'd1;

  logic        pend0;
  logic        pend1;
  logic [31:0] baddr0;
  logic [31:0] bdata0;
  logic [31:0] baddr1;
  logic [31:0] bdata1;
  logic        last_grant;

  logic        grant_vld;
  logic        grant_sel;
  logic [31:0] gaddr;
  logic [31:0] gdata;
  logic [6:0]  gslot;
  logic        in_window;
  logic        drop;

  assign rdy0 = ~pend0;
  assign rdy1 = ~pend1;
  assign busy = pend0 | pend1;

  always_comb begin
    grant_vld = pend0 | pend1;
    grant_sel = 1'b0;
    if (pend0 && pend1) begin
      grant_sel = ~last_grant;
    end else begin
      grant_sel = pend1;
    end
  end

  assign gaddr     = grant_sel ? baddr1 : baddr0;
  assign gdata     = grant_sel ? bdata1 : bdata0;
  assign gslot     = {1'b0, gaddr[7:2]};
  assign in_window = (gslot >= WIN_LO) && (gslot <= WIN_HI);
  assign drop      = grant_vld & ~in_window;

  // Accept and grant of the same requester are mutually exclusive (pend gates both).
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      pend0  <= 1'b0;
      baddr0 <= '0;
      bdata0 <= '0;
    end else if (req0 && rdy0) begin
      pend0  <= 1'b1;
      baddr0 <= addr0;
      bdata0 <= data0;
    end else if (grant_vld && !grant_sel) begin
      pend0  <= 1'b0;
    end
  end

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      pend1  <= 1'b0;
      baddr1 <= '0;
      bdata1 <= '0;
    end else if (req1 && rdy1) begin
      pend1  <= 1'b1;
      baddr1 <= addr1;
      bdata1 <= data1;
    end else if (grant_vld && grant_sel) begin
      pend1  <= 1'b0;
    end
  end

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= 1'b1;
      io_we      <= 1'b0;
      io_addr    <= '0;
      io_data    <= '0;
    end else begin
      io_we <= 1'b0;
      if (grant_vld) begin
        last_grant <= grant_sel;
        if (in_window) begin
          io_we   <= 1'b1;
          io_addr <= gaddr;
          io_data <= gdata;
        end
      end
    end
  end

  // A drop on the same edge as err_clr keeps the flag set.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      err     <= 1'b0;
      err_src <= 1'b0;
    end else if (drop) begin
      err     <= 1'b1;
      err_src <= grant_sel;
    end else if (err_clr) begin
      err     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_write_arbiter.sv
// tb/tb_io_write_arbiter.sv - scoreboard bench for io_write_arbiter with a queue-based reference model
module tb_io_write_arbiter;

  logic        io_clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, err_clr = 1'b0;
  logic [31:0] addr0 = '0, data0 = '0, addr1 = '0, data1 = '0;
  logic        rdy0, rdy1, io_we, busy, err, err_src;
  logic [31:0] io_addr, io_data;

  always #5 io_clk = ~io_clk;

  io_write_arbiter dut (
    .io_clk (io_clk),
    .resetn (resetn),
    .req0   (req0),
    .addr0  (addr0),
    .data0  (data0),
    .rdy0   (rdy0),
    .req1   (req1),
    .addr1  (addr1),
    .data1  (data1),
    .rdy1   (rdy1),
    .io_addr(io_addr),
    .io_data(io_data),
    .io_we  (io_we),
    .busy   (busy),
    .err    (err),
    .err_src(err_src),
    .err_clr(err_clr)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
    int          src;
  } wr_t;

  wr_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  // Reference model state: one-slot buffer per requester plus the round-robin pointer.
  bit          m_pend[2] = '{0, 0};
  logic [31:0] m_addr[2] = '{32'h0, 32'h0};
  logic [31:0] m_data[2] = '{32'h0, 32'h0};
  int          m_last = 1;
  bit          m_err = 0;
  bit          m_src = 0;
  logic [31:0] m_io_addr = '0;
  logic [31:0] m_io_data = '0;
  int          cyc = 0;

  bit stream_on = 0;
  int wr_cnt[2] = '{0, 0};
  int prev_src = -1;
  int prev_cyc = -10;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] rand_addr(input bit win_only);
    logic [31:0] a;
    int slot;
    a = $urandom;
    slot = win_only ? int'($urandom_range(34, 32)) : int'($urandom_range(36, 30));
    a[7:2] = slot[5:0];
    return a;
  endfunction

  initial forever begin
    @(posedge io_clk or negedge resetn);
    if (!resetn) begin
      m_pend    = '{0, 0};
      m_last    = 1;
      m_err     = 0;
      m_src     = 0;
      m_io_addr = '0;
      m_io_data = '0;
      exp_q.delete();
    end else begin
      bit old_pend[2];
      int g;
      bit dropped;
      cyc++;
      old_pend = m_pend;
      g = -1;
      dropped = 0;
      if (m_pend[0] && m_pend[1]) g = (m_last == 0) ? 1 : 0;
      else if (m_pend[0]) g = 0;
      else if (m_pend[1]) g = 1;
      if (g >= 0) begin
        int slot;
        m_pend[g] = 0;
        m_last = g;
        slot = int'(m_addr[g][7:2]);
        if (slot >= 32 && slot <= 34) begin
          wr_t e;
          e.addr = m_addr[g];
          e.data = m_data[g];
          e.cyc  = cyc;
          e.src  = g;
          exp_q.push_back(e);
          m_io_addr = m_addr[g];
          m_io_data = m_data[g];
        end else begin
          dropped = 1;
          m_err = 1;
          m_src = (g == 1);
        end
      end
      if (err_clr && !dropped) m_err = 0;
      if (req0 && !old_pend[0]) begin m_pend[0] = 1; m_addr[0] = addr0; m_data[0] = data0; end
      if (req1 && !old_pend[1]) begin m_pend[1] = 1; m_addr[1] = addr1; m_data[1] = data1; end
    end
  end

  initial forever begin
    @(negedge io_clk);
    if (io_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", io_we, 1'b0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("io_addr", io_addr, e.addr);
        check("io_data", io_data, e.data);
        check("issue_cycle", cyc, e.cyc);
        if (stream_on) begin
          wr_cnt[e.src]++;
          if (prev_cyc == cyc - 1) check("alternate", (e.src != prev_src), 1'b1);
          prev_src = e.src;
          prev_cyc = cyc;
        end
      end
    end
    check("rdy0", rdy0, !m_pend[0]);
    check("rdy1", rdy1, !m_pend[1]);
    check("busy", busy, m_pend[0] | m_pend[1]);
    check("err", err, m_err);
    check("err_src", err_src, m_src);
    check("io_addr_hold", io_addr, m_io_addr);
    check("io_data_hold", io_data, m_io_data);
  end

  task automatic drive(input int n, input int pct, input bit win_only);
    bit took0, took1;
    took0 = 1;
    took1 = 1;
    for (int k = 0; k < n; k++) begin
      @(negedge io_clk);
      if (took0) begin
        req0  = ($urandom_range(99) < pct);
        addr0 = rand_addr(win_only);
        data0 = $urandom;
      end
      if (took1) begin
        req1  = ($urandom_range(99) < pct);
        addr1 = rand_addr(win_only);
        data1 = $urandom;
      end
      err_clr = win_only ? 1'b0 : ($urandom_range(7) == 0);
      took0 = !req0 || rdy0;
      took1 = !req1 || rdy1;
    end
  endtask

  initial begin
    // Reset held with a request present.
    req0 = 1; addr0 = 32'h80; data0 = 32'h1234;
    repeat (3) @(negedge io_clk);
    check("rst_io_we", io_we, 0);
    check("rst_io_addr", io_addr, 0);
    check("rst_io_data", io_data, 0);
    check("rst_rdy0", rdy0, 1);
    check("rst_rdy1", rdy1, 1);
    check("rst_err", err, 0);
    #2 resetn = 1;

    // Single write.
    @(negedge io_clk); req0 = 0;
    check("single_rdy0_low", rdy0, 0);
    @(negedge io_clk);
    check("single_we", io_we, 1);
    check("single_addr", io_addr, 32'h80);
    check("single_data", io_data, 32'h1234);
    check("single_rdy0_back", rdy0, 1);
    @(negedge io_clk);
    check("single_we_one_cycle", io_we, 0);

    // Tie right after reset: requester 0 first.
    #2 resetn = 0;
    @(negedge io_clk); #2 resetn = 1;
    req0 = 1; addr0 = 32'h84; data0 = 32'hA5A5;
    req1 = 1; addr1 = 32'h88; data1 = 32'h5A5A;
    @(negedge io_clk); req0 = 0; req1 = 0;
    @(negedge io_clk);
    check("tie_first_we", io_we, 1);
    check("tie_first_addr", io_addr, 32'h84);
    check("tie_first_data", io_data, 32'hA5A5);
    @(negedge io_clk);
    check("tie_second_we", io_we, 1);
    check("tie_second_addr", io_addr, 32'h88);
    check("tie_second_data", io_data, 32'h5A5A);
    check("tie_last_grant", dut.last_grant, 1);

    // Streaming fairness.
    wr_cnt = '{0, 0};
    prev_cyc = -10;
    stream_on = 1;
    drive(20, 100, 1);
    @(negedge io_clk); req0 = 0; req1 = 0;
    repeat (3) @(negedge io_clk);
    stream_on = 0;
    check("stream_balance", ((wr_cnt[0] - wr_cnt[1]) <= 1) && ((wr_cnt[1] - wr_cnt[0]) <= 1), 1);
    check("stream_volume", (wr_cnt[0] + wr_cnt[1]) >= 18, 1);

    // Drop, then err_clr racing a second drop, then err_clr alone.
    @(negedge io_clk); req1 = 1; addr1 = 32'h8C; data1 = 32'hDEAD;
    @(negedge io_clk); req1 = 0;
    @(negedge io_clk);
    check("drop_no_we", io_we, 0);
    check("drop_err", err, 1);
    check("drop_err_src", err_src, 1);
    req0 = 1; addr0 = 32'h7C; data0 = 32'hBEEF;
    @(negedge io_clk); req0 = 0; err_clr = 1;
    @(negedge io_clk); err_clr = 0;
    check("clr_vs_drop_err", err, 1);
    check("clr_vs_drop_src", err_src, 0);
    @(negedge io_clk); err_clr = 1;
    @(negedge io_clk); err_clr = 0;
    check("clr_alone_err", err, 0);

    // Reset while traffic is in flight.
    drive(6, 100, 1);
    @(posedge io_clk); #3 resetn = 0;
    #1;
    check("midrst_io_we", io_we, 0);
    check("midrst_rdy0", rdy0, 1);
    check("midrst_rdy1", rdy1, 1);
    check("midrst_busy", busy, 0);
    req0 = 0; req1 = 0;
    @(negedge io_clk); #2 resetn = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge io_clk);
      check("no_stale_write", io_we, 0);
    end

    // Randomized mixed traffic including out-of-window writes and clears.
    drive(400, 60, 0);
    @(negedge io_clk); req0 = 0; req1 = 0; err_clr = 0;
    repeat (4) @(negedge io_clk);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
